// File: rtl/xm23_loader_pkg.sv
// Shared types and defaults for the XM23 serial program loader.
// Holds the frame and byte-receiver state encodings plus the default timing/sync constants.
package xm23_loader_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
    localparam logic [7:0]  SYNC_BYTE_DEFAULT    = 8'hA5;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_ADDR_HI,
        FS_ADDR_LO,
        FS_CNT_HI,
        FS_CNT_LO,
        FS_DATA_LO,
        FS_DATA_HI,
        FS_CSUM
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/xm23_prog_loader_if.sv
// Program-RAM write bus and loader status lines.
// The loader drives everything; the RAM/CPU side only observes.
interface xm23_prog_loader_if;

    logic [14:0] pram_address;
    logic [15:0] pram_data;
    logic        pram_wren;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output pram_address,
        output pram_data,
        output pram_wren,
        output busy,
        output done,
        output error
    );

    modport slave (
        input pram_address,
        input pram_data,
        input pram_wren,
        input busy,
        input done,
        input error
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// Emits a one-cycle byte_valid (good stop bit) or frame_err (low stop bit) at the stop-bit sample.
module uart_rx_byte
    import xm23_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       init,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned     CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   FULL_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta_q;
    logic          rx_sync_q;
    logic          rx_prev_q;
    rx_state_e     state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    bit_q,    bit_d;
    logic [7:0]    shift_q,  shift_d;
    logic          full_tick;
    logic          half_tick;

    assign full_tick = (cnt_q == FULL_TICK);
    assign half_tick = (cnt_q == HALF_TICK);

    // Synchronizer and edge-history flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start-bit was only a glitch.
                if (half_tick) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if ((state_q == RX_STOP) && full_tick) begin
            byte_valid = rx_sync_q;
            frame_err  = !rx_sync_q;
        end
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/xm23_prog_loader.sv
// Serial program loader: parses SYNC/address/count/data/checksum frames from the UART
// and writes the received 16-bit words into program RAM.
module xm23_prog_loader
    import xm23_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                init,
    input  logic                rx,
    xm23_prog_loader_if.master  bus
);

    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         rx_frame_err;

    frame_state_e state_q,        state_d;
    logic [14:0]  addr_q,         addr_d;
    logic [15:0]  cnt_q,          cnt_d;
    logic [7:0]   csum_q,         csum_d;
    logic [7:0]   data_lo_q,      data_lo_d;
    logic [14:0]  pram_address_q, pram_address_d;
    logic [15:0]  pram_data_q,    pram_data_d;
    logic         pram_wren_q,    pram_wren_d;
    logic         busy_q,         busy_d;
    logic         done_q,         done_d;
    logic         error_q,        error_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .init       (init),
        .rx         (rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .frame_err  (rx_frame_err)
    );

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q        <= FS_IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            csum_q         <= '0;
            data_lo_q      <= '0;
            pram_address_q <= '0;
            pram_data_q    <= '0;
            pram_wren_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            csum_q         <= csum_d;
            data_lo_q      <= data_lo_d;
            pram_address_q <= pram_address_d;
            pram_data_q    <= pram_data_d;
            pram_wren_q    <= pram_wren_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        csum_d         = csum_q;
        data_lo_d      = data_lo_q;
        pram_address_d = pram_address_q;
        pram_data_d    = pram_data_q;
        pram_wren_d    = 1'b0;
        busy_d         = busy_q;
        done_d         = done_q;
        error_d        = error_q;

        // A broken byte mid-frame abandons the frame; words already written remain.
        if (rx_frame_err && (state_q != FS_IDLE)) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = FS_IDLE;
        end else if (rx_valid) begin
            if ((state_q != FS_IDLE) && (state_q != FS_CSUM)) begin
                csum_d = csum_q ^ rx_byte;
            end
            unique case (state_q)
                FS_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = FS_ADDR_HI;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        csum_d  = '0;
                    end
                end
                FS_ADDR_HI: begin
                    addr_d[14:8] = rx_byte[6:0];
                    state_d      = FS_ADDR_LO;
                end
                FS_ADDR_LO: begin
                    addr_d[7:0] = rx_byte;
                    state_d     = FS_CNT_HI;
                end
                FS_CNT_HI: begin
                    cnt_d[15:8] = rx_byte;
                    state_d     = FS_CNT_LO;
                end
                FS_CNT_LO: begin
                    cnt_d[7:0] = rx_byte;
                    state_d    = ({cnt_q[15:8], rx_byte} == 16'd0) ? FS_CSUM : FS_DATA_LO;
                end
                FS_DATA_LO: begin
                    data_lo_d = rx_byte;
                    state_d   = FS_DATA_HI;
                end
                FS_DATA_HI: begin
                    pram_wren_d    = 1'b1;
                    pram_address_d = addr_q;
                    pram_data_d    = {rx_byte, data_lo_q};
                    addr_d         = addr_q + 15'd1;
                    cnt_d          = cnt_q - 16'd1;
                    state_d        = (cnt_q == 16'd1) ? FS_CSUM : FS_DATA_LO;
                end
                FS_CSUM: begin
                    if (rx_byte == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = FS_IDLE;
                end
                default: begin
                    state_d = FS_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.pram_address = pram_address_q;
        bus.pram_data    = pram_data_q;
        bus.pram_wren    = pram_wren_q;
        bus.busy         = busy_q;
        bus.done         = done_q;
        bus.error        = error_q;
    end

endmodule

// File: tb/tb_xm23_prog_loader.sv
// Scoreboard bench for xm23_prog_loader: serialises frames onto rx and checks RAM writes
// and end-of-frame status against a queue-based reference model.
`timescale 1ns/1ps
module tb_xm23_prog_loader;

    localparam int unsigned CLKS = 16;
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic done;
        logic error;
    } st_t;

    logic clk = 1'b0;
    logic init;
    logic rx;

    xm23_prog_loader_if bus ();

    xm23_prog_loader #(
        .CLKS_PER_BIT (CLKS),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk  (clk),
        .init (init),
        .rx   (rx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    wr_t         expWrites[$];
    st_t         expStatus[$];
    logic [15:0] words[$];
    int          checks = 0;
    int          errors = 0;
    int          bvCount = 0;
    logic [14:0] lastAddr = '0;
    logic [15:0] lastData = '0;
    logic        prevBusy = 1'b0;
    logic        prevBv = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit = 1'b1);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stopBit;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Builds one complete frame from 'words', queues the expected writes and final status,
    // then serialises it. csumXor != 0 deliberately corrupts the checksum byte.
    task automatic applyStimulus(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] csumXor);
        logic [15:0] n;
        logic [7:0]  cs;
        int          addr;
        st_t         st;
        n    = 16'(words.size());
        addr = (int'(hi) % 128) * 256 + int'(lo);
        cs   = hi ^ lo ^ n[15:8] ^ n[7:0];
        foreach (words[i]) begin
            cs = cs ^ words[i][7:0] ^ words[i][15:8];
            expWrites.push_back('{addr: 15'(addr), data: words[i]});
            addr = (addr + 1) % 32768;
        end
        st.done  = (csumXor == 8'h00);
        st.error = (csumXor != 8'h00);
        expStatus.push_back(st);

        sendByte(SYNC);
        checkOutput("busy_after_sync", 32'(bus.busy), 32'd1);
        checkOutput("done_cleared_by_sync", 32'(bus.done), 32'd0);
        checkOutput("error_cleared_by_sync", 32'(bus.error), 32'd0);
        sendByte(hi);
        sendByte(lo);
        sendByte(n[15:8]);
        sendByte(n[7:0]);
        foreach (words[i]) begin
            sendByte(words[i][7:0]);
            sendByte(words[i][15:8]);
        end
        sendByte(cs ^ csumXor);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on each RAM write and on each end of frame.
    always @(negedge clk) begin : monitor
        wr_t w;
        st_t s;
        if (init) begin
            prevBusy = 1'b0;
            prevBv   = 1'b0;
            lastAddr = '0;
            lastData = '0;
        end else begin
            if (bus.pram_wren) begin
                checkOutput("write_latency", 32'(prevBv), 32'd1);
                if (expWrites.size() == 0) begin
                    checkOutput("unexpected_write", 32'(bus.pram_address), 32'hFFFF_FFFF);
                end else begin
                    w = expWrites.pop_front();
                    checkOutput("write_addr", 32'(bus.pram_address), 32'(w.addr));
                    checkOutput("write_data", 32'(bus.pram_data), 32'(w.data));
                    lastAddr = w.addr;
                    lastData = w.data;
                end
            end else begin
                checkOutput("hold_addr", 32'(bus.pram_address), 32'(lastAddr));
                checkOutput("hold_data", 32'(bus.pram_data), 32'(lastData));
            end
            if (prevBusy && !bus.busy) begin
                if (expStatus.size() == 0) begin
                    checkOutput("unexpected_frame_end", 32'd1, 32'd0);
                end else begin
                    s = expStatus.pop_front();
                    checkOutput("frame_done", 32'(bus.done), 32'(s.done));
                    checkOutput("frame_error", 32'(bus.error), 32'(s.error));
                end
            end
            prevBusy = bus.busy;
            prevBv   = dut.u_rx.byte_valid;
            if (dut.u_rx.byte_valid) begin
                bvCount++;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int snap;
        st_t st;
        init = 1'b1;
        rx   = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_addr", 32'(bus.pram_address), 32'd0);
        checkOutput("reset_data", 32'(bus.pram_data), 32'd0);
        checkOutput("reset_wren", 32'(bus.pram_wren), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_error", 32'(bus.error), 32'd0);
        init = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] nominal frame");
        words = '{16'h1234, 16'hABCD};
        applyStimulus(8'h00, 8'h10, 8'h00);
        checkOutput("nominal_busy", 32'(bus.busy), 32'd0);

        $display("[TB] bad checksum frame");
        applyStimulus(8'h00, 8'h10, 8'hFF);

        $display("[TB] address wrap frame");
        words = '{16'h1111, 16'h2222};
        applyStimulus(8'h7F, 8'hFF, 8'h00);

        $display("[TB] zero-count frame");
        words = {};
        applyStimulus(8'h00, 8'h00, 8'h00);

        $display("[TB] stop bit low during address low byte");
        st.done  = 1'b0;
        st.error = 1'b1;
        expStatus.push_back(st);
        sendByte(SYNC);
        sendByte(8'h00);
        sendByte(8'h10, 1'b0);
        repeat (CLKS) @(negedge clk);
        checkOutput("framing_error_flag", 32'(bus.error), 32'd1);
        checkOutput("framing_busy", 32'(bus.busy), 32'd0);
        words = '{16'hBEEF, 16'h0042, 16'hA5A5};
        applyStimulus(8'h01, 8'h00, 8'h00);

        $display("[TB] init between data bytes, then rx glitch");
        sendByte(SYNC);
        sendByte(8'h00);
        sendByte(8'h20);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h55);
        init = 1'b1;
        repeat (3) @(negedge clk);
        init = 1'b0;
        sendByte(8'h66);
        repeat (CLKS) @(negedge clk);
        checkOutput("init_addr", 32'(bus.pram_address), 32'd0);
        checkOutput("init_data", 32'(bus.pram_data), 32'd0);
        checkOutput("init_wren", 32'(bus.pram_wren), 32'd0);
        checkOutput("init_busy", 32'(bus.busy), 32'd0);
        checkOutput("init_done", 32'(bus.done), 32'd0);
        checkOutput("init_error", 32'(bus.error), 32'd0);
        snap = bvCount;
        rx = 1'b0;
        repeat (CLKS * 3 / 10) @(negedge clk);
        rx = 1'b1;
        repeat (CLKS * 12) @(negedge clk);
        checkOutput("glitch_byte_valid", 32'(bvCount - snap), 32'd0);
        checkOutput("glitch_busy", 32'(bus.busy), 32'd0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            logic [7:0] noise;
            logic [7:0] hi;
            logic [7:0] lo;
            logic [7:0] bad;
            int         cnt;
            noise = 8'($urandom);
            if (noise == SYNC) begin
                noise = 8'h5A;
            end
            sendByte(noise);
            hi = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'h7F, 8'hFF) | 8'h7F) : 8'($urandom);
            lo = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'hFC, 8'hFF)) : 8'($urandom);
            cnt = $urandom_range(0, 5);
            words = {};
            for (int i = 0; i < cnt; i++) begin
                words.push_back(16'($urandom));
            end
            bad = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            applyStimulus(hi, lo, bad);
        end

        repeat (20) @(negedge clk);
        checkOutput("writes_drained", 32'(expWrites.size()), 32'd0);
        checkOutput("status_drained", 32'(expStatus.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
